// File: rtl/latch_capture_reader_pkg.sv
// Shared types and helpers for the latch capture reader: FSM state encoding,
// drop counter width and a saturating increment.
package latch_capture_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OPEN   = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  localparam int DROP_CNT_W = 8;

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (v == '1) ? v : v + DROP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/latch_capture_reader_if.sv
// Bundle of the writer-latch inputs, downstream handshake and stats outputs.
// The master side is the writer/consumer environment, the slave side is the reader.
interface latch_capture_reader_if #(parameter int WIDTH = 8);
  import latch_capture_reader_pkg::*;

  logic                  Latch_En;
  logic [WIDTH-1:0]      Latch_Q;
  logic                  Ready;
  logic                  Clear_Stats;
  logic [WIDTH-1:0]      Data_Out;
  logic                  Valid;
  logic                  Overrun;
  logic [DROP_CNT_W-1:0] Drop_Count;
  logic                  Busy;

  modport master (
    output Latch_En, Latch_Q, Ready, Clear_Stats,
    input  Data_Out, Valid, Overrun, Drop_Count, Busy
  );

  modport slave (
    input  Latch_En, Latch_Q, Ready, Clear_Stats,
    output Data_Out, Valid, Overrun, Drop_Count, Busy
  );

endinterface

// File: rtl/latch_capture_reader_level_sync.sv
// Multi-flop synchronizer bringing the writer's asynchronous latch enable into
// the Clk domain; every stage clears on Reset.
module latch_capture_reader_level_sync #(
  parameter int STAGES = 2
) (
  input  logic Clk,
  input  logic Reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) chain <= '0;
    else       chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/latch_capture_reader.sv
// Detects the close of a writer's D-latch, waits for the latch output to settle,
// captures it and offers the word on a valid/ready handshake with drop statistics.
module latch_capture_reader
  import latch_capture_reader_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 2
) (
  input logic                  Clk,
  input logic                  Reset,
  latch_capture_reader_if.slave bus
);

  localparam int                CNT_W    = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic                  en_s, en_d, rise, fall;
  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  capture, drop;
  logic [WIDTH-1:0]      data_q;
  logic                  valid_q, overrun_q;
  logic [DROP_CNT_W-1:0] drop_cnt_q;

  latch_capture_reader_level_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .Clk   (Clk),
    .Reset (Reset),
    .d     (bus.Latch_En),
    .q     (en_s)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) en_d <= 1'b0;
    else       en_d <= en_s;
  end

  assign rise = en_s & ~en_d;
  assign fall = ~en_s & en_d;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // A reopen during the settle window wins over the capture, even on its last cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rise) state_nxt = ST_OPEN;
      end
      ST_OPEN: begin
        if (fall) begin
          state_nxt = ST_SETTLE;
          cnt_nxt   = '0;
        end
      end
      ST_SETTLE: begin
        if (rise) begin
          state_nxt = ST_OPEN;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          capture   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign drop = capture & valid_q & ~bus.Ready;

  // A capture that coincides with an accept replaces the consumed word directly.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (capture && (!valid_q || bus.Ready)) begin
      data_q  <= bus.Latch_Q;
      valid_q <= 1'b1;
    end else if (valid_q && bus.Ready) begin
      valid_q <= 1'b0;
    end
  end

  // A drop in the same cycle as a clear still counts, restarting the tally at one.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      overrun_q  <= 1'b0;
      drop_cnt_q <= '0;
    end else if (drop) begin
      overrun_q  <= 1'b1;
      drop_cnt_q <= bus.Clear_Stats ? DROP_CNT_W'(1) : sat_inc(drop_cnt_q);
    end else if (bus.Clear_Stats) begin
      overrun_q  <= 1'b0;
      drop_cnt_q <= '0;
    end
  end

  assign bus.Data_Out   = data_q;
  assign bus.Valid      = valid_q;
  assign bus.Overrun    = overrun_q;
  assign bus.Drop_Count = drop_cnt_q;
  assign bus.Busy       = (state != ST_IDLE);

endmodule
